// File: rtl/wakeup_select_rr_if.sv
// wakeup_select_rr_if: request/flush/handshake and registered grant bundle
// between the issue-queue wakeup logic and the issue stage.
interface wakeup_select_rr_if #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
);
  logic [ENTRIES-1:0] request_IN;
  logic               flush_IN;
  logic               issue_ready_IN;
  logic               Issue_OUT;
  logic [IDX_W-1:0]   grant_index_OUT;
  logic [ENTRIES-1:0] grant_onehot_OUT;
  logic [IDX_W-1:0]   rr_ptr_OUT;
  modport master (
    output request_IN, flush_IN, issue_ready_IN,
    input  Issue_OUT, grant_index_OUT, grant_onehot_OUT, rr_ptr_OUT
  );
  modport slave (
    input  request_IN, flush_IN, issue_ready_IN,
    output Issue_OUT, grant_index_OUT, grant_onehot_OUT, rr_ptr_OUT
  );
endinterface

// File: rtl/wakeup_select_rr.sv
// wakeup_select_rr: picks one ready issue-queue entry per cycle (fixed or
// round-robin priority) into a registered grant held under valid/ready.
module wakeup_select_rr #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter bit RR_MODE = 1'b1
) (
  input logic             CLOCK,
  input logic             RESET,
  wakeup_select_rr_if.slave bus
);
  logic               issue_q, issue_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ENTRIES-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               xfer, stall, found, load;
  logic [ENTRIES-1:0] cand;
  logic [IDX_W-1:0]   sel, base;
  logic [IDX_W:0]     j;
  assign xfer  = issue_q & bus.issue_ready_IN;
  assign stall = issue_q & ~bus.issue_ready_IN;
  // the entry leaving this cycle may still request; keep it from re-issuing
  assign cand  = bus.request_IN & ~(xfer ? onehot_q : '0);
  assign base  = RR_MODE ? ptr_q : '0;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      j = {1'b0, base} + (IDX_W+1)'(i);
      j = (j >= (IDX_W+1)'(ENTRIES)) ? j - (IDX_W+1)'(ENTRIES) : j;
      if (cand[j[IDX_W-1:0]]) begin
        sel   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign load     = ~bus.flush_IN & ~stall & found;
  assign issue_d  = bus.flush_IN ? 1'b0 : stall ? issue_q : found;
  assign idx_d    = load ? sel : idx_q;
  assign onehot_d = bus.flush_IN ? '0 : stall ? onehot_q : found ? (ENTRIES'(1) << sel) : '0;
  assign ptr_d    = bus.flush_IN ? '0 :
                    (load && RR_MODE) ? ((sel == IDX_W'(ENTRIES - 1)) ? '0 : sel + IDX_W'(1)) :
                    ptr_q;
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      issue_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      issue_q  <= issue_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end
  assign bus.Issue_OUT        = issue_q;
  assign bus.grant_index_OUT  = idx_q;
  assign bus.grant_onehot_OUT = onehot_q;
  assign bus.rr_ptr_OUT       = ptr_q;
endmodule

// File: tb/tb_wakeup_select_rr.sv
// tb_wakeup_select_rr: directed scenarios plus random traffic on a fixed-priority,
// a round-robin and an odd-sized round-robin instance, checked against a scan model.
module tb_wakeup_select_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] req = '0;
  logic flush = 1'b0;
  logic rdy = 1'b1;
  int dut_sel = 0;
  int checks = 0;
  int failures = 0;
  typedef struct { bit iss; int idx; int ptr; } ms_t;
  ms_t m[3];
  logic obs_iss;
  int obs_idx, obs_ptr;
  logic [31:0] obs_oh;
  always #5 clk = ~clk;
  wakeup_select_rr_if #(.ENTRIES(16), .IDX_W(4)) if_fp ();
  wakeup_select_rr_if #(.ENTRIES(16), .IDX_W(4)) if_rr ();
  wakeup_select_rr_if #(.ENTRIES(6),  .IDX_W(3)) if_od ();
  wakeup_select_rr #(.ENTRIES(16), .IDX_W(4), .RR_MODE(1'b0)) u_fp (.CLOCK(clk), .RESET(rst_n), .bus(if_fp));
  wakeup_select_rr #(.ENTRIES(16), .IDX_W(4), .RR_MODE(1'b1)) u_rr (.CLOCK(clk), .RESET(rst_n), .bus(if_rr));
  wakeup_select_rr #(.ENTRIES(6),  .IDX_W(3), .RR_MODE(1'b1)) u_od (.CLOCK(clk), .RESET(rst_n), .bus(if_od));
  assign if_fp.request_IN     = (dut_sel == 0) ? req[15:0] : '0;
  assign if_rr.request_IN     = (dut_sel == 1) ? req[15:0] : '0;
  assign if_od.request_IN     = (dut_sel == 2) ? req[5:0]  : '0;
  assign if_fp.flush_IN       = (dut_sel == 0) ? flush : 1'b0;
  assign if_rr.flush_IN       = (dut_sel == 1) ? flush : 1'b0;
  assign if_od.flush_IN       = (dut_sel == 2) ? flush : 1'b0;
  assign if_fp.issue_ready_IN = (dut_sel == 0) ? rdy : 1'b1;
  assign if_rr.issue_ready_IN = (dut_sel == 1) ? rdy : 1'b1;
  assign if_od.issue_ready_IN = (dut_sel == 2) ? rdy : 1'b1;
  always_comb begin
    obs_iss = (dut_sel == 0) ? if_fp.Issue_OUT : (dut_sel == 1) ? if_rr.Issue_OUT : if_od.Issue_OUT;
    obs_idx = (dut_sel == 0) ? int'(if_fp.grant_index_OUT) : (dut_sel == 1) ? int'(if_rr.grant_index_OUT) : int'(if_od.grant_index_OUT);
    obs_ptr = (dut_sel == 0) ? int'(if_fp.rr_ptr_OUT) : (dut_sel == 1) ? int'(if_rr.rr_ptr_OUT) : int'(if_od.rr_ptr_OUT);
    obs_oh  = (dut_sel == 0) ? 32'(if_fp.grant_onehot_OUT) : (dut_sel == 1) ? 32'(if_rr.grant_onehot_OUT) : 32'(if_od.grant_onehot_OUT);
  end
  function automatic int n_of(int d); return (d == 2) ? 6 : 16; endfunction
  function automatic bit rr_of(int d); return d != 0; endfunction
  // Reference: scan the entries in priority order starting at the pointer, taking the first live one.
  function automatic ms_t model_next(ms_t s, int n, bit rr, logic [31:0] rq, bit fl, bit rd);
    ms_t r = s;
    logic [31:0] c = rq;
    int pick = -1;
    if (fl) begin
      r.iss = 1'b0;
      r.ptr = 0;
      return r;
    end
    if (s.iss && !rd) return r;
    if (s.iss) c[s.idx] = 1'b0;
    for (int k = 0; k < n; k++) begin
      int e = rr ? (s.ptr + k) % n : k;
      if (pick < 0 && c[e]) pick = e;
    end
    r.iss = (pick >= 0);
    if (pick >= 0) begin
      r.idx = pick;
      if (rr) r.ptr = (pick + 1) % n;
    end
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      logic [31:0] rq = (d == dut_sel) ? (req & ((32'd1 << n_of(d)) - 32'd1)) : 32'd0;
      if (!rst_n) m[d] = '{1'b0, 0, 0};
      else m[d] = model_next(m[d], n_of(d), rr_of(d), rq, (d == dut_sel) ? flush : 1'b0, (d == dut_sel) ? rdy : 1'b1);
    end
    #1;
  endtask
  task automatic test_reset();
    dut_sel = 1;
    checks++;
    if (obs_iss !== 1'b0 || obs_idx !== 0 || obs_oh !== 0 || obs_ptr !== 0) begin
      failures++;
      $display("FAIL reset_initial: iss=%b idx=%0d oh=%h ptr=%0d, required all zero", obs_iss, obs_idx, obs_oh, obs_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 32'h0010;
    step();
    checks++;
    if (obs_iss !== 1'b1 || obs_idx !== 4 || obs_ptr !== 5) begin
      failures++;
      $display("FAIL reset_pregrant: iss=%b idx=%0d ptr=%0d, required 1/4/5", obs_iss, obs_idx, obs_ptr);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) m[d] = '{1'b0, 0, 0};
    checks++;
    if (obs_iss !== 1'b0 || obs_idx !== 0 || obs_oh !== 0 || obs_ptr !== 0) begin
      failures++;
      $display("FAIL reset_async: iss=%b idx=%0d oh=%h ptr=%0d, required all zero", obs_iss, obs_idx, obs_oh, obs_ptr);
    end
    req = 32'h0;
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (obs_iss !== 1'b0 || obs_oh !== 0) begin
        failures++;
        $display("FAIL reset_idle: iss=%b oh=%h, required 0/0", obs_iss, obs_oh);
      end
    end
  endtask
  task automatic test_fixed_priority();
    dut_sel = 0;
    rdy = 1'b1;
    req = 32'h8012;
    for (int i = 0; i < 8; i++) begin
      int e = (i % 2) ? 4 : 1;
      step();
      checks++;
      if (obs_iss !== 1'b1 || obs_idx !== e || obs_oh !== (32'd1 << e) || obs_ptr !== 0) begin
        failures++;
        $display("FAIL fixed_prio[%0d]: iss=%b idx=%0d oh=%h ptr=%0d, required 1/%0d/%h/0", i, obs_iss, obs_idx, obs_oh, obs_ptr, e, 32'd1 << e);
      end
    end
    req = 32'h0;
    step();
  endtask
  task automatic test_round_robin();
    int ei[3] = '{1, 4, 15};
    int ep[3] = '{2, 5, 0};
    dut_sel = 1;
    rdy = 1'b1;
    flush = 1'b1;
    req = 32'h0;
    step();
    flush = 1'b0;
    req = 32'h8012;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs_iss !== 1'b1 || obs_idx !== ei[i%3] || obs_ptr !== ep[i%3] || obs_oh !== (32'd1 << ei[i%3])) begin
        failures++;
        $display("FAIL round_robin[%0d]: iss=%b idx=%0d ptr=%0d oh=%h, required 1/%0d/%0d", i, obs_iss, obs_idx, obs_ptr, obs_oh, ei[i%3], ep[i%3]);
      end
    end
  endtask
  task automatic test_stall();
    dut_sel = 1;
    rdy = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req = 32'h0010;
    step();
    rdy = 1'b0;
    req = 32'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_iss !== 1'b1 || obs_idx !== 4 || obs_oh !== 32'h10 || obs_ptr !== 5) begin
        failures++;
        $display("FAIL stall_hold[%0d]: iss=%b idx=%0d oh=%h ptr=%0d, required 1/4/10/5", i, obs_iss, obs_idx, obs_oh, obs_ptr);
      end
    end
    rdy = 1'b1;
    step();
    checks++;
    if (obs_iss !== 1'b1 || obs_idx !== 0 || obs_ptr !== 1) begin
      failures++;
      $display("FAIL stall_release: iss=%b idx=%0d ptr=%0d, required 1/0/1", obs_iss, obs_idx, obs_ptr);
    end
  endtask
  task automatic test_flush_stall();
    dut_sel = 1;
    rdy = 1'b1;
    req = 32'h0100;
    step();
    checks++;
    if (obs_iss !== 1'b1 || obs_idx !== 8 || obs_ptr !== 9) begin
      failures++;
      $display("FAIL flush_setup: iss=%b idx=%0d ptr=%0d, required 1/8/9", obs_iss, obs_idx, obs_ptr);
    end
    rdy = 1'b0;
    flush = 1'b1;
    req = 32'hFFFF;
    step();
    checks++;
    if (obs_iss !== 1'b0 || obs_oh !== 0 || obs_ptr !== 0) begin
      failures++;
      $display("FAIL flush_stall: iss=%b oh=%h ptr=%0d, required 0/0/0", obs_iss, obs_oh, obs_ptr);
    end
    flush = 1'b0;
    step();
    checks++;
    if (obs_iss !== 1'b1 || obs_idx !== 0 || obs_ptr !== 1) begin
      failures++;
      $display("FAIL flush_after: iss=%b idx=%0d ptr=%0d, required 1/0/1", obs_iss, obs_idx, obs_ptr);
    end
    rdy = 1'b1;
  endtask
  task automatic test_odd_wrap();
    dut_sel = 2;
    rdy = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req = 32'h21;
    for (int i = 0; i < 6; i++) begin
      int e = (i % 2) ? 5 : 0;
      int p = (i % 2) ? 0 : 1;
      step();
      checks++;
      if (obs_iss !== 1'b1 || obs_idx !== e || obs_ptr !== p || obs_idx > 5) begin
        failures++;
        $display("FAIL odd_wrap[%0d]: iss=%b idx=%0d ptr=%0d, required 1/%0d/%0d", i, obs_iss, obs_idx, obs_ptr, e, p);
      end
    end
  endtask
  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      dut_sel = d;
      for (int i = 0; i < 300; i++) begin
        req = (i % 3 == 0) ? $urandom : ($urandom & $urandom & $urandom);
        rdy = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 19) == 0);
        step();
        checks++;
        if (obs_iss !== m[d].iss || obs_ptr !== m[d].ptr || (m[d].iss && obs_idx !== m[d].idx)) begin
          failures++;
          $display("FAIL random_d%0d[%0d]: iss=%b idx=%0d ptr=%0d, required %b/%0d/%0d", d, i, obs_iss, obs_idx, obs_ptr, m[d].iss, m[d].idx, m[d].ptr);
        end
        checks++;
        if (obs_oh !== (m[d].iss ? (32'd1 << m[d].idx) : 32'd0) || obs_idx >= n_of(d)) begin
          failures++;
          $display("FAIL random_onehot_d%0d[%0d]: oh=%h idx=%0d, required %h", d, i, obs_oh, obs_idx, m[d].iss ? (32'd1 << m[d].idx) : 32'd0);
        end
      end
      flush = 1'b0;
      rdy = 1'b1;
      req = 32'h0;
      step();
    end
  endtask
  initial begin
    for (int d = 0; d < 3; d++) m[d] = '{1'b0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_stall();
    test_flush_stall();
    test_odd_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wakeup_select_rr.md
Name: wakeup_select_rr

Overview:
- Parametrised successor to the issue-queue wakeup/select arbiter.
- Each cycle it picks one ready entry from an ENTRIES-wide request vector. Selection is either fixed lowest-index priority or round-robin.
- The grant is held in an output register under a valid/ready handshake with the execute stage.
- Sits between the issue-queue wakeup logic and the issue/register-read stage. Supports stall, flush, and suppression of double-issue of the entry just consumed.

Parameters:
- ENTRIES, 16, number of issue-queue entries; must be >= 2; need not be a power of two.
- IDX_W, 4, grant index width; must equal ceil(log2(ENTRIES)).
- RR_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin starting at the rotating pointer.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- request_IN  in  ENTRIES  bit i = entry i is woken up and ready to issue.
- flush_IN  in  1  synchronous pipeline flush.
- issue_ready_IN  in  1  downstream stage accepts the current grant this cycle.
- Issue_OUT  out  1  registered: grant_index_OUT/grant_onehot_OUT are valid.
- grant_index_OUT  out  IDX_W  registered index of the granted entry.
- grant_onehot_OUT  out  ENTRIES  registered one-hot grant; all-zero when Issue_OUT = 0.
- rr_ptr_OUT  out  IDX_W  current round-robin start pointer (debug/verification).

Behaviour:
- Reset (RESET = 0, asynchronous): Issue_OUT = 0, grant_index_OUT = 0, grant_onehot_OUT = 0, rr_ptr_OUT = 0. Outputs stay there until the first rising edge after RESET returns to 1.
- Handshake:
  - The output slot is free when Issue_OUT = 0, or when Issue_OUT = 1 and issue_ready_IN = 1 (transfer).
  - When Issue_OUT = 1 and issue_ready_IN = 0 (stall), all outputs and the pointer hold, regardless of request_IN.
- Candidate vector: cand = request_IN & ~mask.
  - mask = grant_onehot_OUT on a transfer cycle; otherwise mask = 0.
  - This keeps the entry being consumed, whose request may still be high for one cycle, from being re-granted.
- Selection when the slot is free:
  - RR_MODE = 0: lowest set index of cand.
  - RR_MODE = 1: first set bit of cand scanning rr_ptr, rr_ptr+1, ..., ENTRIES-1, then wrapping to 0, ..., rr_ptr-1.
- Result of selection:
  - Exactly one grant bit is set. Issue_OUT <= 1, grant_index_OUT <= selected index, grant_onehot_OUT <= 1 << index.
  - If cand = 0: Issue_OUT <= 0, grant_onehot_OUT <= 0, grant_index_OUT holds its previous value.
- Latency: a request present at edge N appears granted after edge N. Request-to-Issue_OUT latency is 1 cycle; a stalled slot adds latency.
- Pointer update (RR_MODE = 1 only):
  - On a cycle that loads a new valid grant at index k, rr_ptr <= k+1, wrapping ENTRIES-1 -> 0.
  - Otherwise rr_ptr holds.
  - RR_MODE = 0: rr_ptr is fixed at 0.
- Flush: flush_IN = 1 has priority over stall and selection. Next edge: Issue_OUT <= 0, grant_onehot_OUT <= 0, rr_ptr <= 0. request_IN is ignored that cycle.
- Throughput: with issue_ready_IN held at 1 and requests available, one grant per cycle, back-to-back.
- Invariants:
  - grant_onehot_OUT is zero or one-hot, and equals 1 << grant_index_OUT whenever Issue_OUT = 1.
  - A granted index always had its request_IN bit set in the selection cycle.
- Non-power-of-two ENTRIES: indices >= ENTRIES never appear; wrap occurs at ENTRIES-1.

Test Plan:
- Reset and idle:
  - Stimulus: assert RESET = 0 mid-operation while Issue_OUT = 1, then release with request_IN = 0.
  - Required: all outputs 0 immediately (asynchronous); Issue_OUT stays 0.
- Fixed priority (RR_MODE = 0, ENTRIES = 16):
  - Stimulus: request_IN = 0x8012 held, issue_ready_IN = 1.
  - Required: grant_index_OUT sequence 1, 4, 1, 4, ...
  - Reason: the consumed entry is masked for one cycle, so 1 and 4 alternate while entry 15 starves.
- Round-robin (RR_MODE = 1):
  - Stimulus: request_IN = 0x8012 held, issue_ready_IN = 1.
  - Required: grant_index_OUT = 1, 4, 15, 1, 4, 15; rr_ptr_OUT = 2, 5, 0, 2, ...
- Stall:
  - Stimulus: grant at index 4, then issue_ready_IN = 0 for 3 cycles while request_IN changes to 0x0001.
  - Required: Issue_OUT = 1 and grant_index_OUT = 4 held for all 3 cycles; index 0 is granted the cycle after issue_ready_IN returns to 1.
- Flush during stall:
  - Stimulus: Issue_OUT = 1, issue_ready_IN = 0, flush_IN = 1, request_IN = 0xFFFF.
  - Required: next cycle Issue_OUT = 0, grant_onehot_OUT = 0, rr_ptr_OUT = 0; the following cycle grants index 0.
- Wrap and odd size (ENTRIES = 6, IDX_W = 3, RR_MODE = 1):
  - Stimulus: request_IN = 6'b100001 held, issue_ready_IN = 1.
  - Required: grants alternate 0, 5, 0, 5; rr_ptr wraps 5 -> 0; index never exceeds 5.
